dram_block_sched: RTL and testbench

Scheduler for the DRAM-backed output queue. It treats DRAM as a ring of fixed-size blocks and decides, one transfer at a time, whether the DRAM engine moves a block from the input FIFO into DRAM (write) or from DRAM to the output FIFO (read). It also decides when the shortcut path may bypass DRAM. It sits between the queue register block (`block_num`, `shortcut_disable`) and the DRAM transfer engine, and produces the per-word/per-block status pulses consumed by the counters.

---
 rtl/dram_queue_pkg.sv | 16 +
 rtl/dram_block_ring.sv | 49 ++++
 rtl/dram_block_sched.sv | 120 ++++++++++++
 tb/tb_dram_block_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dram_queue_pkg.sv
// dram_queue_pkg: shared constants for the DRAM-backed output queue.
// Holds the scheduler state encoding and the read/write grant-priority values.
package dram_queue_pkg;

  // Scheduler states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_BUSY = 2'd1;
  localparam logic [1:0] ST_RD_BUSY = 2'd2;

  // Round-robin token. When it holds GRANT_WR, a read wins a tie; when it
  // holds GRANT_RD, a write wins. The token flips on every grant.
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;
  localparam logic LAST_GRANT_RST = GRANT_WR;  // reads win the first tie

endpackage

// File: rtl/dram_block_ring.sv
// dram_block_ring: DRAM block ring bookkeeping.
// Holds write/read block pointers, occupancy and the ring limit. The limit is
// loaded during reset and reloaded whenever latch_lim is raised. The
// scheduler raises it only in empty idle cycles.
module dram_block_ring #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] block_num,
  input  logic          latch_lim,
  input  logic          wr_adv,
  input  logic          rd_adv,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   blocks_used,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   U_ONE = (AW+1)'(1);

  logic [AW-1:0] lim;
  logic [AW:0]   cap;

  // The ring holds lim+1 blocks
  assign cap   = {1'b0, lim} + U_ONE;
  assign full  = (blocks_used == cap);
  assign empty = (blocks_used == '0);

  // Pointer, occupancy and limit state. A write and a read never complete in
  // the same cycle, so occupancy moves by at most one.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      blocks_used <= '0;
      lim         <= block_num;
    end else begin
      if (latch_lim) lim <= block_num;
      if (wr_adv) wr_ptr <= (wr_ptr == lim) ? '0 : wr_ptr + P_ONE;
      if (rd_adv) rd_ptr <= (rd_ptr == lim) ? '0 : rd_ptr + P_ONE;
      if (wr_adv & ~rd_adv)      blocks_used <= blocks_used + U_ONE;
      else if (rd_adv & ~wr_adv) blocks_used <= blocks_used - U_ONE;
    end
  end

endmodule

// File: rtl/dram_block_sched.sv
// dram_block_sched: picks one DRAM block transfer at a time.
// A transfer is either a write (input FIFO to DRAM) or a read (DRAM to
// output FIFO). The block also gates the DRAM-bypass shortcut.
// Optional feature: define DRAM_SCHED_WATCHDOG_EN to abort transfers that see
// no done pulse within TIMEOUT_CYCLES busy cycles. An aborted block is
// retried with the same address.
module dram_block_sched
  import dram_queue_pkg::*;
#(
  parameter int DRAM_BLOCK_ADDR_WIDTH = 3,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DRAM_BLOCK_ADDR_WIDTH-1:0] block_num,
  input  logic                             shortcut_disable,
  input  logic                             in_block_ready,
  input  logic                             out_block_space,
  output logic                             wr_start,
  output logic                             rd_start,
  output logic [DRAM_BLOCK_ADDR_WIDTH-1:0] xfer_addr,
  input  logic                             wr_done,
  input  logic                             rd_done,
  output logic                             shortcut_active,
  output logic [DRAM_BLOCK_ADDR_WIDTH:0]   blocks_used,
  output logic                             xfer_error
);

  localparam int AW = DRAM_BLOCK_ADDR_WIDTH;

  logic [1:0]    state;
  logic          last_grant;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic          wr_ok, rd_ok, grant_wr, grant_rd;
  logic          wr_adv, rd_adv, latch_lim, timeout;

  assign wr_ok = in_block_ready & ~shortcut_active & ~full;
  assign rd_ok = out_block_space & ~empty;

  // A tie goes to whichever side the round-robin token favours
  assign grant_wr = (state == ST_IDLE) & wr_ok & (~rd_ok | (last_grant == GRANT_RD));
  assign grant_rd = (state == ST_IDLE) & rd_ok & (~wr_ok | (last_grant == GRANT_WR));

  // Done pulses count only when they match the transfer in flight
  assign wr_adv    = (state == ST_WR_BUSY) & wr_done;
  assign rd_adv    = (state == ST_RD_BUSY) & rd_done;
  assign latch_lim = (state == ST_IDLE) & empty;

  dram_block_ring #(.AW(AW)) u_ring (
    .clk         (clk),
    .reset       (reset),
    .block_num   (block_num),
    .latch_lim   (latch_lim),
    .wr_adv      (wr_adv),
    .rd_adv      (rd_adv),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .blocks_used (blocks_used),
    .full        (full),
    .empty       (empty)
  );

`ifdef DRAM_SCHED_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;

  // The TIMEOUT_CYCLES-th busy cycle with no matching done aborts the transfer
  assign timeout = (((state == ST_WR_BUSY) & ~wr_done) | ((state == ST_RD_BUSY) & ~rd_done)) &
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Count busy cycles; the count restarts at zero in idle
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) wd_cnt <= '0;
    else                           wd_cnt <= wd_cnt + WD_W'(1);
  end

  // One-cycle error pulse per abort
  always_ff @(posedge clk) begin
    if (reset) xfer_error <= 1'b0;
    else       xfer_error <= timeout;
  end
`else
  assign timeout    = 1'b0;
  assign xfer_error = 1'b0;
`endif

  // FSM, registered start pulses, transfer address and shortcut gate
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      last_grant      <= LAST_GRANT_RST;
      wr_start        <= 1'b0;
      rd_start        <= 1'b0;
      xfer_addr       <= '0;
      shortcut_active <= 1'b0;
    end else begin
      wr_start        <= grant_wr;
      rd_start        <= grant_rd;
      shortcut_active <= ~shortcut_disable & (state == ST_IDLE) & empty & out_block_space;
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            state      <= ST_WR_BUSY;
            xfer_addr  <= wr_ptr;
            last_grant <= ~last_grant;
          end else if (grant_rd) begin
            state      <= ST_RD_BUSY;
            xfer_addr  <= rd_ptr;
            last_grant <= ~last_grant;
          end
        end
        ST_WR_BUSY: if (wr_done || timeout) state <= ST_IDLE;
        ST_RD_BUSY: if (rd_done || timeout) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_block_sched.sv
// tb_dram_block_sched: randomized/directed scoreboard bench for dram_block_sched.
// A reference model keeps DRAM contents as a queue of block addresses. Read
// addresses come from the queue head, and occupancy is the queue size.
// Expectations are pushed each rising edge. A monitor pops them on the
// falling edge and compares.
module tb_dram_block_sched;

  localparam int AW = 3;
  localparam int TO = 16;
`ifdef DRAM_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, shortcut_disable, in_block_ready, out_block_space, wr_done, rd_done;
  logic [AW-1:0] block_num, xfer_addr;
  logic wr_start, rd_start, shortcut_active, xfer_error;
  logic [AW:0] blocks_used;

  always #5 clk = ~clk;

  dram_block_sched #(.DRAM_BLOCK_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .block_num(block_num), .shortcut_disable(shortcut_disable),
    .in_block_ready(in_block_ready), .out_block_space(out_block_space),
    .wr_start(wr_start), .rd_start(rd_start), .xfer_addr(xfer_addr),
    .wr_done(wr_done), .rd_done(rd_done), .shortcut_active(shortcut_active),
    .blocks_used(blocks_used), .xfer_error(xfer_error)
  );

  typedef struct {
    logic wr, rd, sc, err;
    logic [AW-1:0] addr;
    logic [AW:0] used;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;
  bit hold = 0, spur = 0;

  // Reference model state
  int dq[$];          // block addresses currently stored in DRAM, oldest first
  int m_busy = 0;     // 0 idle, 1 writing, 2 reading
  int m_wptr = 0, m_lim = 0, m_addr = 0, m_wd = 0;
  bit m_rd_pref = 1, m_sc = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluates the scheduling rules at each rising edge
  always @(posedge clk) begin : model
    exp_t e;
    bit wok, rok, gw, gr, nsc;
    int used;
    e = '{default: '0};
    if (reset) begin
      dq.delete(); m_busy = 0; m_wptr = 0; m_addr = 0; m_wd = 0;
      m_rd_pref = 1; m_sc = 0; m_lim = int'(block_num);
    end else begin
      used = dq.size();
      wok = in_block_ready && !m_sc && (used != m_lim + 1);
      rok = out_block_space && (used != 0);
      nsc = !shortcut_disable && m_busy == 0 && used == 0 && out_block_space;
      gw = 0; gr = 0;
      if (m_busy == 0) begin
        if (wok && rok) begin gr = m_rd_pref; gw = !m_rd_pref; end
        else begin gw = wok; gr = rok; end
        if (gw) begin m_busy = 1; m_addr = m_wptr; end
        if (gr) begin m_busy = 2; m_addr = dq[0]; end
        if (gw || gr) m_rd_pref = !m_rd_pref;
        if (used == 0) m_lim = int'(block_num);
        m_wd = 0;
      end else if (m_busy == 1 && wr_done) begin
        dq.push_back(m_wptr);
        m_wptr = (m_wptr == m_lim) ? 0 : (m_wptr + 1) % (1 << AW);
        m_busy = 0;
      end else if (m_busy == 2 && rd_done) begin
        void'(dq.pop_front());
        m_busy = 0;
      end else begin
        m_wd++;
        if (WD && m_wd == TO) begin e.err = 1'b1; m_busy = 0; end
      end
      m_sc = nsc;
      e.wr = gw; e.rd = gr;
    end
    e.addr = m_addr[AW-1:0];
    e.sc   = m_sc;
    e.used = dq.size();
    sbq.push_back(e);
  end

  // Monitor: compares DUT outputs against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("wr_start", {7'd0, wr_start}, {7'd0, e.wr});
      chk("rd_start", {7'd0, rd_start}, {7'd0, e.rd});
      chk("shortcut_active", {7'd0, shortcut_active}, {7'd0, e.sc});
      chk("blocks_used", {4'd0, blocks_used}, {4'd0, e.used});
      chk("xfer_error", {7'd0, xfer_error}, {7'd0, e.err});
      if (e.wr || e.rd) chk("xfer_addr", {5'd0, xfer_addr}, {5'd0, e.addr});
    end
  end

  // DRAM engine stand-in: answers each start with its done after 1-4 cycles,
  // optionally sprinkling done pulses of the wrong kind
  initial begin : responder
    int pend = 0;
    bit lastwr = 0;
    wr_done = 0; rd_done = 0;
    forever begin
      @(negedge clk);
      wr_done = 0; rd_done = 0;
      if (wr_start || rd_start) begin
        lastwr = wr_start;
        pend = $urandom_range(1, 4);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && !hold) begin
          if (lastwr) wr_done = 1; else rd_done = 1;
        end
      end
      if (spur && $urandom_range(0, 7) == 0) begin
        if (lastwr) rd_done = 1; else wr_done = 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic rdy, input logic spc, input logic dis);
    in_block_ready = rdy; out_block_space = spc; shortcut_disable = dis;
  endtask

  // Directed scenarios, then randomized traffic
  initial begin : stim
    int n;
    reset = 1; block_num = 3; set_in(0, 0, 1);
    cyc(3);
    reset = 0;
    set_in(1, 0, 1); cyc(40);          // fill four blocks, then stall full
    set_in(0, 1, 1); cyc(40);          // drain in order
    set_in(1, 0, 1); cyc(10);          // next write wraps to block 0
    set_in(1, 1, 1); cyc(60);          // both eligible: round-robin
    set_in(0, 1, 0); cyc(40);          // drain; shortcut rises when empty
    set_in(1, 1, 0); cyc(10);          // shortcut blocks writes
    set_in(1, 0, 0); cyc(20);          // shortcut falls, write granted
    // Limit change while the ring is non-empty
    reset = 1; cyc(2); reset = 0;
    set_in(1, 0, 1);
    n = 0;
    while (blocks_used != 2 && n < 100) begin cyc(1); n++; end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL fill_to_two timeout actual=%0d expected=2", blocks_used);
    end
    in_block_ready = 0; block_num = 1; cyc(10);
    in_block_ready = 1; cyc(30);       // still wraps at 3
    set_in(0, 1, 1); cyc(40);          // drain; new limit takes hold
    set_in(1, 0, 1); cyc(30);          // now wraps at 1
    // Random traffic with spurious done pulses and occasional resets
    spur = 1;
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 49) == 0) block_num = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    reset = 0; spur = 0;
`ifdef DRAM_SCHED_WATCHDOG_EN
    reset = 1; block_num = 3; cyc(2); reset = 0;
    hold = 1; set_in(1, 0, 1); cyc(60);
    hold = 0; cyc(20);
`endif
    set_in(0, 0, 1); cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
